counter_up_down_param: RTL and testbench
========================================

Name: counter_up_down_param

Overview:
- Parametrised up/down counter with runtime modulus, variable step, wrap/saturate mode and registered overflow/underflow pulses.
- Successor to the fixed 8-bit load/up/down counter; used for address sequencing, timers and credit tracking.
- Counts in range 0..max_val; single clock domain.

Parameters:
WIDTH, 8, counter and data width in bits (>=2)
STEP_W, 4, width of the step input (1..WIDTH)
WRAP, 1, 1 = wrap modulo (max_val+1) at bounds; 0 = saturate at bounds

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear to 0
load  input  1  synchronous load of data_in
data_in  input  WIDTH  load value
en  input  1  count enable
m  input  1  direction: 1 = up, 0 = down
step  input  STEP_W  increment/decrement magnitude, zero-extended to WIDTH+1
max_val  input  WIDTH  runtime upper bound (inclusive)
count  output  WIDTH  registered count
tc_up  output  1  combinational: count == max_val
tc_dn  output  1  combinational: count == 0
ovf  output  1  registered one-cycle pulse: up-count crossed max_val
unf  output  1  registered one-cycle pulse: down-count crossed 0
ld_clip  output  1  registered one-cycle pulse: load value clamped

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0): count=0, ovf=0, unf=0, ld_clip=0 immediately. tc_dn=1; tc_up=(max_val==0).
- Priority per rising edge: clr > load > range-fix > en count > hold.
- ovf, unf and ld_clip default to 0 every cycle. They pulse only in the cycle after the causing edge.
- clr=1: count<=0, no flags.
- load=1 (clr=0):
  - count<=min(data_in, max_val).
  - ld_clip<=1 iff data_in > max_val.
  - en and m ignored.
- Range-fix: if count > max_val (max_val lowered at runtime) and no clr/load, count<=max_val regardless of en. No ovf.
- en=0 or step=0: hold, no flags.
- Up (en=1, m=1): sum = count + step, computed in WIDTH+1 bits.
  - sum <= max_val: count<=sum.
  - sum > max_val, WRAP=1, step <= max_val: count<=sum-(max_val+1); ovf<=1.
  - sum > max_val, WRAP=1, step > max_val: count<=max_val; ovf<=1. No multi-lap wrap; no divider.
  - sum > max_val, WRAP=0: count<=max_val; ovf<=1 only if count != max_val before the edge.
- Down (en=1, m=0):
  - step <= count: count<=count-step.
  - step > count, WRAP=1, step <= max_val: count<=count+(max_val+1)-step; unf<=1.
  - step > count, WRAP=1, step > max_val: count<=0; unf<=1.
  - step > count, WRAP=0: count<=0; unf<=1 only if count != 0 before the edge.
- Arithmetic: all intermediates WIDTH+1 bits. max_val = 2^WIDTH-1 gives a full binary counter, identical to plain modular wrap.
- max_val=0: count pinned at 0. WRAP=1 with en=1 and step>0 pulses ovf (up) or unf (down) every cycle.
- Async rst assertion mid-operation clears all state at once. Deassertion takes effect at the next clk edge; the first post-reset edge may count.

Test Plan:
- Reset/flags: rst=0 while count=0x55 -> count=0x00 immediately, ovf=unf=ld_clip=0, tc_dn=1.
- Up wrap: WIDTH=8, WRAP=1, max_val=9, count=8, step=3, m=1, en=1 -> count=1, ovf=1 for one cycle. Next edge with step=1 -> count=2, ovf=0.
- Down wrap/saturate: max_val=9, count=1, step=3, m=0 -> WRAP=1: count=8, unf=1. WRAP=0: count=0, unf=1. Repeating with WRAP=0 -> count=0, unf=0.
- Load clip and priority: max_val=0x20, load=1, data_in=0x40, en=1 -> count=0x20, ld_clip=1. Same cycle with clr=1 -> count=0, ld_clip=0.
- Runtime bound change: count=0x30, max_val drops 0xFF->0x10, en=0 -> next edge count=0x10, tc_up=1, ovf=0.
- Full-range: max_val=0xFF, count=0xFE, step=2, up -> count=0x00, ovf=1. Then step=1, down -> count=0xFF, unf=1.

Source files
------------

// File: rtl/counter_up_down_param.sv
// Up/down counter bounded by a runtime max_val, with variable step, wrap or
// saturate behaviour at the bounds, and registered ovf/unf/ld_clip pulses.
module counter_up_down_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int WRAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              en,
  input  logic              m,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              ovf,
  output logic              unf,
  output logic              ld_clip
);

  localparam int EW = WIDTH + 1;
  typedef logic [EW-1:0] ext_t;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             clip_q, clip_d;

  ext_t           count_x, step_x, max_x;
  logic [WIDTH:0] up_r, dn_r;

  // Returns {ovf, next_count}; caller guarantees cnt <= mx.
  function automatic logic [WIDTH:0] count_up(ext_t cnt, ext_t stp, ext_t mx);
    ext_t sum;
    sum = cnt + stp;
    if (sum <= mx) return {1'b0, WIDTH'(sum)};
    if (WRAP != 0) begin
      if (stp <= mx) return {1'b1, WIDTH'(sum - mx - ext_t'(1))};
      return {1'b1, WIDTH'(mx)};
    end
    return {cnt != mx, WIDTH'(mx)};
  endfunction

  // Returns {unf, next_count}; caller guarantees cnt <= mx.
  function automatic logic [WIDTH:0] count_dn(ext_t cnt, ext_t stp, ext_t mx);
    if (stp <= cnt) return {1'b0, WIDTH'(cnt - stp)};
    if (WRAP != 0) begin
      if (stp <= mx) return {1'b1, WIDTH'(cnt + mx + ext_t'(1) - stp)};
      return {1'b1, {WIDTH{1'b0}}};
    end
    return {cnt != '0, {WIDTH{1'b0}}};
  endfunction

  assign count_x = {1'b0, count_q};
  assign max_x   = {1'b0, max_val};
  assign step_x  = {{(EW-STEP_W){1'b0}}, step};
  assign up_r    = count_up(count_x, step_x, max_x);
  assign dn_r    = count_dn(count_x, step_x, max_x);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    clip_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (data_in > max_val) begin
        count_d = max_val;
        clip_d  = 1'b1;
      end else begin
        count_d = data_in;
      end
    end else if (count_q > max_val) begin
      // max_val was lowered underneath us: pull back into range silently.
      count_d = max_val;
    end else if (en && (step != '0)) begin
      if (m) begin
        count_d = up_r[WIDTH-1:0];
        ovf_d   = up_r[WIDTH];
      end else begin
        count_d = dn_r[WIDTH-1:0];
        unf_d   = dn_r[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      clip_q  <= clip_d;
    end
  end

  assign count   = count_q;
  assign tc_up   = (count_q == max_val);
  assign tc_dn   = (count_q == '0);
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign ld_clip = clip_q;

endmodule

// File: tb/tb_counter_up_down_param.sv
// Scoreboard bench: a wrapping and a saturating instance share stimulus;
// the driver queues hand-computed results and a monitor checks each edge.
module tb_counter_up_down_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0, m = 1'b0;
  logic [7:0] data_in = '0, max_val = 8'hFF;
  logic [3:0] step = '0;

  logic [7:0] cnt_w, cnt_s;
  logic       tcu_w, tcd_w, ovf_w, unf_w, clip_w;
  logic       tcu_s, tcd_s, ovf_s, unf_s, clip_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] c1;
    logic       o1, u1, l1, tu, td;
    logic [7:0] c0;
    logic       o0, u0, l0;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  counter_up_down_param #(.WIDTH(8), .STEP_W(4), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .data_in(data_in),
    .en(en), .m(m), .step(step), .max_val(max_val),
    .count(cnt_w), .tc_up(tcu_w), .tc_dn(tcd_w),
    .ovf(ovf_w), .unf(unf_w), .ld_clip(clip_w)
  );

  counter_up_down_param #(.WIDTH(8), .STEP_W(4), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .data_in(data_in),
    .en(en), .m(m), .step(step), .max_val(max_val),
    .count(cnt_s), .tc_up(tcu_s), .tc_dn(tcd_s),
    .ovf(ovf_s), .unf(unf_s), .ld_clip(clip_s)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic vec(input logic c, input logic ld, input logic [7:0] din,
                     input logic e, input logic dir, input logic [3:0] st,
                     input logic [7:0] mx, input string nm,
                     input logic [7:0] c1, input logic o1, input logic u1,
                     input logic l1, input logic tu, input logic td,
                     input logic [7:0] c0, input logic o0, input logic u0,
                     input logic l0);
    exp_t x;
    @(negedge clk);
    clr = c; load = ld; data_in = din; en = e; m = dir; step = st; max_val = mx;
    x.name = nm;
    x.c1 = c1; x.o1 = o1; x.u1 = u1; x.l1 = l1; x.tu = tu; x.td = td;
    x.c0 = c0; x.o0 = o0; x.u0 = u0; x.l0 = l0;
    exp_q.push_back(x);
  endtask

  // Monitor: every edge with a queued expectation is checked 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".wrap.count"},   32'(cnt_w),  32'(e.c1));
        check({e.name, ".wrap.ovf"},     32'(ovf_w),  32'(e.o1));
        check({e.name, ".wrap.unf"},     32'(unf_w),  32'(e.u1));
        check({e.name, ".wrap.ld_clip"}, 32'(clip_w), 32'(e.l1));
        check({e.name, ".wrap.tc_up"},   32'(tcu_w),  32'(e.tu));
        check({e.name, ".wrap.tc_dn"},   32'(tcd_w),  32'(e.td));
        check({e.name, ".sat.count"},    32'(cnt_s),  32'(e.c0));
        check({e.name, ".sat.ovf"},      32'(ovf_s),  32'(e.o0));
        check({e.name, ".sat.unf"},      32'(unf_s),  32'(e.u0));
        check({e.name, ".sat.ld_clip"},  32'(clip_s), 32'(e.l0));
      end
    end
  end

  initial begin
    int guard;
    #1;
    check("rst0.count",  32'(cnt_w), 32'h0);
    check("rst0.tc_dn",  32'(tcd_w), 32'h1);
    check("rst0.tc_up",  32'(tcu_w), 32'h0);
    max_val = 8'h00;
    #1;
    check("rst0.tc_up_max0", 32'(tcu_w), 32'h1);
    max_val = 8'hFF;
    @(negedge clk);
    rst = 1'b1;

    //   clr ld din    en m st  max    name          c1    o u l tu td  c0    o u l
    vec(0, 1, 8'h55, 0, 0, 0, 8'hFF, "load55",     8'h55, 0,0,0, 0,0, 8'h55, 0,0,0);

    // Async reset mid-cycle, away from any clock edge.
    @(negedge clk);
    load = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst.count_wrap", 32'(cnt_w),  32'h0);
    check("arst.count_sat",  32'(cnt_s),  32'h0);
    check("arst.ovf",        32'(ovf_w),  32'h0);
    check("arst.unf",        32'(unf_w),  32'h0);
    check("arst.ld_clip",    32'(clip_w), 32'h0);
    check("arst.tc_dn",      32'(tcd_w),  32'h1);
    @(negedge clk);
    rst = 1'b1;

    vec(0, 1, 8'h08, 0, 0, 0, 8'h09, "ld8",        8'h08, 0,0,0, 0,0, 8'h08, 0,0,0);
    vec(0, 0, 8'h00, 1, 1, 3, 8'h09, "upwrap",     8'h01, 1,0,0, 0,0, 8'h09, 1,0,0);
    vec(0, 0, 8'h00, 1, 1, 1, 8'h09, "up1",        8'h02, 0,0,0, 0,0, 8'h09, 0,0,0);
    vec(0, 1, 8'h01, 0, 0, 0, 8'h09, "ld1",        8'h01, 0,0,0, 0,0, 8'h01, 0,0,0);
    vec(0, 0, 8'h00, 1, 0, 3, 8'h09, "dnwrap",     8'h08, 0,1,0, 0,0, 8'h00, 0,1,0);
    vec(0, 0, 8'h00, 1, 0, 3, 8'h09, "dnagain",    8'h05, 0,0,0, 0,0, 8'h00, 0,0,0);
    vec(0, 1, 8'h40, 1, 1, 1, 8'h20, "ldclip",     8'h20, 0,0,1, 1,0, 8'h20, 0,0,1);
    vec(1, 1, 8'h40, 1, 1, 1, 8'h20, "clrprio",    8'h00, 0,0,0, 0,1, 8'h00, 0,0,0);
    vec(0, 1, 8'h30, 0, 0, 0, 8'hFF, "ld30",       8'h30, 0,0,0, 0,0, 8'h30, 0,0,0);
    vec(0, 0, 8'h00, 0, 0, 0, 8'h10, "rangefix",   8'h10, 0,0,0, 1,0, 8'h10, 0,0,0);
    vec(0, 1, 8'h30, 0, 0, 0, 8'hFF, "ld30b",      8'h30, 0,0,0, 0,0, 8'h30, 0,0,0);
    vec(0, 0, 8'h00, 1, 1, 5, 8'h10, "rangefixen", 8'h10, 0,0,0, 1,0, 8'h10, 0,0,0);
    vec(0, 1, 8'hFE, 0, 0, 0, 8'hFF, "ldFE",       8'hFE, 0,0,0, 0,0, 8'hFE, 0,0,0);
    vec(0, 0, 8'h00, 1, 1, 2, 8'hFF, "fullup",     8'h00, 1,0,0, 0,1, 8'hFF, 1,0,0);
    vec(0, 0, 8'h00, 1, 0, 1, 8'hFF, "fulldn",     8'hFF, 0,1,0, 1,0, 8'hFE, 0,0,0);
    vec(0, 0, 8'h00, 1, 1, 1, 8'h00, "max0fix",    8'h00, 0,0,0, 1,1, 8'h00, 0,0,0);
    vec(0, 0, 8'h00, 1, 1, 1, 8'h00, "max0up",     8'h00, 1,0,0, 1,1, 8'h00, 0,0,0);
    vec(0, 0, 8'h00, 1, 0, 1, 8'h00, "max0dn",     8'h00, 0,1,0, 1,1, 8'h00, 0,0,0);
    vec(0, 1, 8'h05, 0, 0, 0, 8'h09, "ld5",        8'h05, 0,0,0, 0,0, 8'h05, 0,0,0);
    vec(0, 0, 8'h00, 1, 0, 0, 8'h09, "step0",      8'h05, 0,0,0, 0,0, 8'h05, 0,0,0);
    vec(0, 0, 8'h00, 0, 1, 3, 8'h09, "en0",        8'h05, 0,0,0, 0,0, 8'h05, 0,0,0);
    vec(0, 0, 8'h00, 1, 1, 4, 8'h09, "uptomax",    8'h09, 0,0,0, 1,0, 8'h09, 0,0,0);
    vec(0, 0, 8'h00, 1, 1, 15, 8'h09, "upbigstep", 8'h09, 1,0,0, 1,0, 8'h09, 0,0,0);
    vec(0, 0, 8'h00, 1, 0, 15, 8'h09, "dnbigstep", 8'h00, 0,1,0, 0,1, 8'h00, 0,1,0);

    @(negedge clk);
    en = 1'b0; load = 1'b0; clr = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
